// File: rtl/led_arb_pkg.sv
// Shared types and defaults for the LED strip arbiter: FSM state encoding,
// default timing constants and a one-hot to index helper.
package led_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    START = 3'd2,
    SEND  = 3'd3,
    GAP   = 3'd4
  } state_e;

  // 2500 cycles is the 50 us WS2811 latch at 50 MHz.
  localparam int DEF_GAP_CYCLES     = 2500;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

  function automatic int onehot_to_index(input logic [31:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (((onehot >> i) & 32'd1) != 32'd0) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/led_strip_arbiter_if.sv
// Bundle between the frame sources / WS2811 driver and the strip arbiter.
// The arbiter side uses the slave modport; sources and driver use master.
interface led_strip_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  import led_arb_pkg::*;

  // Handshake: a source holds req[i] high (level) until it sees frame_ack[i];
  // the arbiter pulses start_frame for one cycle with grant/sel already
  // stable, and the driver answers with a one-cycle frame_done pulse.
  logic [N_REQ-1:0] req;
  logic             frame_done;
  logic [N_REQ-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic             start_frame;
  logic [N_REQ-1:0] frame_ack;
  logic             busy;
  logic             timeout_err;
  state_e           dbg_state;

  modport master (
    output req, frame_done,
    input  grant, sel, start_frame, frame_ack, busy, timeout_err, dbg_state
  );

  modport slave (
    input  req, frame_done,
    output grant, sel, start_frame, frame_ack, busy, timeout_err, dbg_state
  );

endinterface

// File: rtl/led_arb_pick.sv
// Combinational winner picker. Fixed priority (index 0 wins) by default;
// define LED_ARB_ROUND_ROBIN_EN to search upward from last_owner+1 instead.
module led_arb_pick
  import led_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int SEL_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_owner,
  output logic [N_REQ-1:0] grant_next,
  output logic [SEL_W-1:0] sel_next
);

`ifdef LED_ARB_ROUND_ROBIN_EN
  int start_idx;
  int cand;

  // Walk the search order backwards so the earliest candidate overwrites last.
  always_comb begin
    grant_next = '0;
    cand       = 0;
    start_idx  = (int'(last_owner) + 1) % N_REQ;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = (start_idx + i) % N_REQ;
      if (((req >> cand) & N_REQ'(1)) != '0) grant_next = N_REQ'(1) << cand;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = ^last_owner;

  always_comb begin
    grant_next = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (((req >> i) & N_REQ'(1)) != '0) grant_next = N_REQ'(1) << i;
    end
  end
`endif

  assign sel_next = SEL_W'(onehot_to_index(32'(grant_next)));

endmodule

// File: rtl/led_strip_arbiter.sv
// Shares one WS2811 array driver between N_REQ frame sources, one frame per
// grant, with a latch gap after each frame. Macro LED_ARB_ROUND_ROBIN_EN.
module led_strip_arbiter
  import led_arb_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SEL_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clock,
  input  logic               reset,
  led_strip_arbiter_if.slave bus
);

  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             terr_q, terr_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  logic [N_REQ-1:0] grant_next;
  logic [SEL_W-1:0] sel_next;
  logic [SEL_W-1:0] last_owner;
  logic             any_req;

  assign any_req = |bus.req;

  led_arb_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req        (bus.req),
    .last_owner (last_owner),
    .grant_next (grant_next),
    .sel_next   (sel_next)
  );

`ifdef LED_ARB_ROUND_ROBIN_EN
  logic [SEL_W-1:0] last_owner_q, last_owner_d;

  // Resetting to N_REQ-1 makes the very first search start at index 0.
  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == ARB && any_req) last_owner_d = sel_next;
  end

  always_ff @(posedge clock) begin
    if (reset) last_owner_q <= SEL_W'(N_REQ - 1);
    else       last_owner_q <= last_owner_d;
  end

  assign last_owner = last_owner_q;
`else
  assign last_owner = SEL_W'(N_REQ - 1);
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    start_d = 1'b0;
    ack_d   = '0;
    terr_d  = terr_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) state_d = ARB;
      end
      ARB: begin
        if (any_req) begin
          state_d = START;
          grant_d = grant_next;
          sel_d   = sel_next;
          start_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        tmo_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        // frame_done wins over a timeout landing in the same cycle.
        if (bus.frame_done) begin
          ack_d   = grant_q;
          gap_d   = GW'(GAP_CYCLES - 1);
          state_d = GAP;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          terr_d  = 1'b1;
          gap_d   = GW'(GAP_CYCLES - 1);
          state_d = GAP;
        end else if (tmo_q != {TW{1'b1}}) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      GAP: begin
        // grant/sel stay put until the latch gap has fully elapsed.
        if (gap_q == '0) begin
          grant_d = '0;
          sel_d   = '0;
          state_d = any_req ? ARB : IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == START) || (state_d == SEND) || (state_d == GAP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      start_q <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      gap_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.sel         = sel_q;
  assign bus.start_frame = start_q;
  assign bus.frame_ack   = ack_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_led_strip_arbiter.sv
// Directed bench for led_strip_arbiter: expected start_frame/frame_ack events
// (cycle, grant, sel) are queued by the driver and popped by a monitor.
module tb_led_strip_arbiter;
  import led_arb_pkg::*;

  localparam int N_REQ = 3;
  localparam int GAP   = 4;
  localparam int TMO   = 20;
  localparam int SEL_W = 2;
  localparam int SW    = 16 + N_REQ + SEL_W;
  localparam int AW    = 16 + N_REQ;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  logic [SW-1:0] exp_start_q[$];
  logic [AW-1:0] exp_ack_q[$];
  logic [SW-1:0] exp_s;
  logic [AW-1:0] exp_a;

  led_strip_arbiter_if #(.N_REQ(N_REQ), .SEL_W(SEL_W)) bus ();

  led_strip_arbiter #(
    .N_REQ          (N_REQ),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .SEL_W          (SEL_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_grant"}, 32'(bus.grant), 32'd0);
    check({name, "_sel"}, 32'(bus.sel), 32'd0);
    check({name, "_start"}, 32'(bus.start_frame), 32'd0);
    check({name, "_ack"}, 32'(bus.frame_ack), 32'd0);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_terr"}, 32'(bus.timeout_err), 32'd0);
    check({name, "_state"}, 32'(bus.dbg_state), 32'(IDLE));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    bus.frame_done = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic expect_start(input int c, input logic [N_REQ-1:0] g, input logic [SEL_W-1:0] s);
    exp_start_q.push_back({16'(c), g, s});
  endtask

  task automatic expect_ack(input int c, input logic [N_REQ-1:0] g);
    exp_ack_q.push_back({16'(c), g});
  endtask

  task automatic pulse_done(input int t);
    wait_cyc(t);
    bus.frame_done = 1'b1;
    step();
    bus.frame_done = 1'b0;
  endtask

  // Frame starting at cycle s, frame_done on SEND cycle l.
  task automatic run_frame(input int s, input int l, input logic [N_REQ-1:0] g,
                           input logic [SEL_W-1:0] sl);
    expect_start(s, g, sl);
    pulse_done(s + l);
    expect_ack(s + l + 1, g);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    checks++;
    if ($countones(bus.grant) > 1) begin
      errors++;
      $display("FAIL grant_onehot: got grant %b, required one-hot or zero (cycle %0d)", bus.grant, cyc);
    end
    if (bus.start_frame === 1'b1) begin
      checks++;
      if (exp_start_q.size() == 0) begin
        errors++;
        $display("FAIL start_frame: got unexpected pulse grant %b at cycle %0d, required none", bus.grant, cyc);
      end else begin
        exp_s = exp_start_q.pop_front();
        if ({16'(cyc), bus.grant, bus.sel} !== exp_s || bus.dbg_state !== START) begin
          errors++;
          $display("FAIL start_frame: got cycle %0d grant %b sel %0d state %0d, required cycle %0d grant %b sel %0d state START",
                   cyc, bus.grant, bus.sel, bus.dbg_state, exp_s[SW-1 -: 16],
                   exp_s[SEL_W+N_REQ-1 -: N_REQ], exp_s[SEL_W-1:0]);
        end
      end
    end
    if (bus.frame_ack !== '0) begin
      checks++;
      if (exp_ack_q.size() == 0) begin
        errors++;
        $display("FAIL frame_ack: got unexpected ack %b at cycle %0d, required none", bus.frame_ack, cyc);
      end else begin
        exp_a = exp_ack_q.pop_front();
        if ({16'(cyc), bus.frame_ack} !== exp_a) begin
          errors++;
          $display("FAIL frame_ack: got cycle %0d ack %b, required cycle %0d ack %b",
                   cyc, bus.frame_ack, exp_a[AW-1 -: 16], exp_a[N_REQ-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [N_REQ-1:0] exp_g[4];
  logic [SEL_W-1:0] exp_sel[4];
  int               lens[4];

  initial begin
    int b;
    int s;
    bus.req = '0;
    bus.frame_done = 1'b0;
    lens = '{3, 5, 2, 4};
`ifdef LED_ARB_ROUND_ROBIN_EN
    exp_g   = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd0};
`else
    exp_g   = '{3'b001, 3'b001, 3'b001, 3'b001};
    exp_sel = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif

    // 1: reset, then 50 idle cycles with no requests.
    repeat (3) step();
    reset = 1'b0;
    check_idle("reset");
    b = cyc;
    wait_cyc(b + 50);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_grant", 32'(bus.grant), 32'd0);

    // 2: single request from index 1, frame_done on SEND cycle 7.
    do_reset();
    b = cyc;
    bus.req = 3'b010;
    expect_start(b + 2, 3'b010, 2'd1);
    wait_cyc(b + 5);
    check("send_grant", 32'(bus.grant), 32'b010);
    check("send_sel", 32'(bus.sel), 32'd1);
    check("send_busy", 32'(bus.busy), 32'd1);
    check("send_state", 32'(bus.dbg_state), 32'(SEND));
    pulse_done(b + 10);
    expect_ack(b + 11, 3'b010);
    bus.req = '0;
    wait_cyc(b + 14);
    check("gap_last_busy", 32'(bus.busy), 32'd1);
    check("gap_hold_grant", 32'(bus.grant), 32'b010);
    check("gap_state", 32'(bus.dbg_state), 32'(GAP));
    step();
    check("after_gap_busy", 32'(bus.busy), 32'd0);
    check("after_gap_grant", 32'(bus.grant), 32'd0);
    check("after_gap_state", 32'(bus.dbg_state), 32'(IDLE));

    // 3: all three request continuously; starts spaced by SEND length + 6.
    do_reset();
    b = cyc;
    bus.req = 3'b111;
    s = b + 2;
    for (int k = 0; k < 4; k++) begin
      run_frame(s, lens[k], exp_g[k], exp_sel[k]);
      s = s + lens[k] + 6;
    end
    bus.req = '0;
    wait_cyc(s - 1);
    check("multi_end_state", 32'(bus.dbg_state), 32'(IDLE));
    check("multi_end_busy", 32'(bus.busy), 32'd0);

    // 4: owner drops req mid-SEND; frame still completes.
    do_reset();
    b = cyc;
    bus.req = 3'b001;
    expect_start(b + 2, 3'b001, 2'd0);
    wait_cyc(b + 4);
    bus.req = '0;
    pulse_done(b + 5);
    expect_ack(b + 6, 3'b001);
    wait_cyc(b + 9);
    check("drop_gap_state", 32'(bus.dbg_state), 32'(GAP));
    step();
    check("drop_end_state", 32'(bus.dbg_state), 32'(IDLE));
    check("drop_end_busy", 32'(bus.busy), 32'd0);

    // 5: no frame_done -> timeout after 20 SEND cycles, sticky error.
    do_reset();
    b = cyc;
    bus.req = 3'b100;
    expect_start(b + 2, 3'b100, 2'd2);
    wait_cyc(b + 22);
    check("tmo_before", 32'(bus.timeout_err), 32'd0);
    check("tmo_send_state", 32'(bus.dbg_state), 32'(SEND));
    step();
    check("tmo_set", 32'(bus.timeout_err), 32'd1);
    check("tmo_gap_state", 32'(bus.dbg_state), 32'(GAP));
    check("tmo_gap_grant", 32'(bus.grant), 32'b100);
    run_frame(b + 28, 2, 3'b100, 2'd2);
    bus.req = '0;
    wait_cyc(b + 40);
    check("tmo_sticky", 32'(bus.timeout_err), 32'd1);
    check("tmo_end_busy", 32'(bus.busy), 32'd0);
    do_reset();
    check_idle("tmo_cleared");

    // 6: reset mid-SEND, spurious frame_done in IDLE, reset mid-GAP.
    b = cyc;
    bus.req = 3'b010;
    expect_start(b + 2, 3'b010, 2'd1);
    wait_cyc(b + 5);
    reset = 1'b1;
    step();
    check_idle("rst_send");
    reset = 1'b0;
    bus.req = '0;
    pulse_done(b + 8);
    wait_cyc(b + 12);
    check("spurious_state", 32'(bus.dbg_state), 32'(IDLE));
    check("spurious_busy", 32'(bus.busy), 32'd0);
    b = cyc;
    bus.req = 3'b010;
    expect_start(b + 2, 3'b010, 2'd1);
    pulse_done(b + 4);
    expect_ack(b + 5, 3'b010);
    bus.req = '0;
    wait_cyc(b + 6);
    check("rst_gap_pre", 32'(bus.dbg_state), 32'(GAP));
    reset = 1'b1;
    step();
    check_idle("rst_gap");
    reset = 1'b0;
    repeat (10) step();

    // ---------------- final report ----------------
    check("start_q_empty", 32'(exp_start_q.size()), 32'd0);
    check("ack_q_empty", 32'(exp_ack_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
